// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding modes, canonical constants and operand classification.
package fpu_pkg;

   localparam int unsigned FP_W  = 32;
   localparam int unsigned EXP_W = 8;
   localparam int unsigned FRC_W = 23;
   localparam int unsigned SIG_W = FRC_W + 1;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } r_mode_e;

   localparam logic [FP_W-1:0]  FP_QNAN = 32'h7fc00000;
   localparam logic [EXP_W-1:0] FP_BIAS = 8'd127;

   // Subnormals are folded into zero: the datapath flushes them.
   typedef struct packed {
      logic zero;
      logic inf;
      logic nan;
   } fp_class_t;

   // Classify a single-precision operand for special-case handling.
   function automatic fp_class_t fp_classify(input logic [FP_W-1:0] f);
      fp_class_t c;
      c.zero = (f[30:23] == 8'h00);
      c.inf  = (f[30:23] == 8'hff) && (f[22:0] == 23'h0);
      c.nan  = (f[30:23] == 8'hff) && (f[22:0] != 23'h0);
      return c;
   endfunction

endpackage

// File: rtl/fp_round_unit.sv
// Combinational significand rounding shared by the FPU divider and multiplier.
module fp_round_unit
   import fpu_pkg::*;
(
   input  logic [SIG_W-1:0] sig,
   input  logic             guard,
   input  logic             sticky,
   input  logic             sign,
   input  logic [2:0]       r_mode,
   output logic [SIG_W-1:0] sig_r,
   output logic             carry
);

   logic           inc;
   logic [SIG_W:0] sum;

   // Pick the increment for the mode; unknown encodings round to nearest-even.
   always_comb begin
      inc = 1'b0;
      case (r_mode)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (guard | sticky);
         RM_RUP:  inc = ~sign & (guard | sticky);
         RM_RMM:  inc = guard;
         default: inc = guard & (sticky | sig[0]);
      endcase
      sum   = {1'b0, sig} + (SIG_W+1)'(inc);
      carry = sum[SIG_W];
      sig_r = carry ? {1'b1, {(SIG_W-1){1'b0}}} : sum[SIG_W-1:0];
   end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative single-precision divider: restoring radix-2 mantissa division with handshakes.
module fp_div_seq
   import fpu_pkg::*;
#(
   parameter int unsigned ITER_PER_CYCLE = 1,
   parameter bit          SPECIAL_BYPASS = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] fp_X,
   input  logic [31:0] fp_Y,
   input  logic [2:0]  r_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] fp_Z,
   output logic        ovrf,
   output logic        udrf,
   output logic        dz
);

   localparam int unsigned QUO_W  = 26;
   localparam int unsigned REM_W  = 25;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned N_STEP = QUO_W / ITER_PER_CYCLE;

   typedef enum logic [2:0] {S_IDLE, S_DIV, S_RND, S_SPEC, S_OUT} state_e;

   state_e            state_q, state_d;
   logic [31:0]       x_q, x_d, y_q, y_d;
   logic [2:0]        rm_q, rm_d;
   logic              sign_q, sign_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [QUO_W-1:0]  quo_q, quo_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       fp_z_q, fp_z_d;
   logic              ovrf_q, ovrf_d, udrf_q, udrf_d, dz_q, dz_d;

   logic [REM_W-1:0]  d_sig, div_rem;
   logic [QUO_W-1:0]  div_quo;
   fp_class_t         cls_x, cls_y, cls_in_x, cls_in_y;
   logic              spec_hit, spec_in, spec_dz;
   logic [31:0]       spec_z;
   logic [SIG_W-1:0]  nrm_sig, rnd_sig;
   logic              nrm_g, nrm_st, rnd_carry;
   logic [9:0]        ex10, ey10, bias10;
   logic signed [9:0] e_pre, e_rnd;

   assign d_sig = {2'b01, y_q[22:0]};

   // Resolve ITER_PER_CYCLE quotient bits from the current partial remainder.
   always_comb begin
      div_rem = rem_q;
      div_quo = quo_q;
      for (int unsigned i = 0; i < ITER_PER_CYCLE; i++) begin
         if (div_rem >= d_sig) begin
            div_rem = div_rem - d_sig;
            div_quo = {div_quo[QUO_W-2:0], 1'b1};
         end else begin
            div_quo = {div_quo[QUO_W-2:0], 1'b0};
         end
         div_rem = div_rem << 1;
      end
   end

   // Special-operand result, by priority: NaN cases, inf dividend, divide-by-zero, zero result.
   always_comb begin
      cls_x    = fp_classify(x_q);
      cls_y    = fp_classify(y_q);
      cls_in_x = fp_classify(fp_X);
      cls_in_y = fp_classify(fp_Y);
      spec_hit = (|cls_x) | (|cls_y);
      spec_in  = (|cls_in_x) | (|cls_in_y);
      spec_dz  = 1'b0;
      spec_z   = {sign_q, 31'h0};
      if (cls_x.nan | cls_y.nan | (cls_x.zero & cls_y.zero) | (cls_x.inf & cls_y.inf)) begin
         spec_z = FP_QNAN;
      end else if (cls_x.inf) begin
         spec_z = {sign_q, 8'hff, 23'h0};
      end else if (cls_y.zero) begin
         spec_z  = {sign_q, 8'hff, 23'h0};
         spec_dz = 1'b1;
      end
   end

   // Normalise the 26-bit quotient into significand, guard and sticky plus biased exponent.
   always_comb begin
      ex10   = {2'b00, x_q[30:23]};
      ey10   = {2'b00, y_q[30:23]};
      bias10 = {2'b00, FP_BIAS};
      if (quo_q[QUO_W-1]) begin
         nrm_sig = quo_q[25:2];
         nrm_g   = quo_q[1];
         nrm_st  = quo_q[0] | (rem_q != '0);
         e_pre   = $signed(ex10 - ey10 + bias10);
      end else begin
         nrm_sig = quo_q[24:1];
         nrm_g   = quo_q[0];
         nrm_st  = (rem_q != '0);
         e_pre   = $signed(ex10 - ey10 + bias10 - 10'd1);
      end
      e_rnd = e_pre + $signed({9'd0, rnd_carry});
   end

   fp_round_unit u_round (
      .sig    (nrm_sig),
      .guard  (nrm_g),
      .sticky (nrm_st),
      .sign   (sign_q),
      .r_mode (rm_q),
      .sig_r  (rnd_sig),
      .carry  (rnd_carry)
   );

   // Next-state and registered-output logic for the divide sequencer.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      rm_d        = rm_q;
      sign_d      = sign_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      fp_z_d      = fp_z_q;
      ovrf_d      = ovrf_q;
      udrf_d      = udrf_q;
      dz_d        = dz_q;
      out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               x_d     = fp_X;
               y_d     = fp_Y;
               rm_d    = r_mode;
               sign_d  = fp_X[31] ^ fp_Y[31];
               rem_d   = {2'b01, fp_X[22:0]};
               quo_d   = '0;
               cnt_d   = '0;
               ovrf_d  = 1'b0;
               udrf_d  = 1'b0;
               dz_d    = 1'b0;
               state_d = (SPECIAL_BYPASS && spec_in) ? S_SPEC : S_DIV;
            end
         end
         S_DIV: begin
            rem_d = div_rem;
            quo_d = div_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N_STEP - 1)) state_d = S_RND;
         end
         S_RND: begin
            if (spec_hit) begin
               fp_z_d = spec_z;
               dz_d   = spec_dz;
            end else if (e_rnd >= 10'sd255) begin
               ovrf_d = 1'b1;
               fp_z_d = {sign_q, 8'hff, 23'h0};
            end else if (e_rnd <= 10'sd0) begin
               udrf_d = 1'b1;
               fp_z_d = {sign_q, 31'h0};
            end else begin
               fp_z_d = {sign_q, 8'(e_rnd), 23'(rnd_sig)};
            end
            state_d = S_OUT;
         end
         S_SPEC: begin
            fp_z_d  = spec_z;
            dz_d    = spec_dz;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_valid_q && out_ready) state_d = S_IDLE;
            else                          out_valid_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d = (state_d == S_IDLE);
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         rm_q        <= '0;
         sign_q      <= 1'b0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         fp_z_q      <= '0;
         ovrf_q      <= 1'b0;
         udrf_q      <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         rm_q        <= rm_d;
         sign_q      <= sign_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         fp_z_q      <= fp_z_d;
         ovrf_q      <= ovrf_d;
         udrf_q      <= udrf_d;
         dz_q        <= dz_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign fp_Z      = fp_z_q;
   assign ovrf      = ovrf_q;
   assign udrf      = udrf_q;
   assign dz        = dz_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: arithmetic reference model, per-cycle output compare, directed vectors.
module tb_fp_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] fp_X, fp_Y, fp_Z;
   logic [2:0]  r_mode;
   logic        ovrf, udrf, dz;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [34:0] exp_q[$];

   always #5 clk = ~clk;

   fp_div_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fp_X      (fp_X),
      .fp_Y      (fp_Y),
      .r_mode    (r_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fp_Z      (fp_Z),
      .ovrf      (ovrf),
      .udrf      (udrf),
      .dz        (dz)
   );

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Reference: long division of the mantissas as integers, then the rounding rules.
   // Result packing is {ovrf, udrf, dz, fp_Z}.
   function automatic logic [34:0] model_div(input logic [31:0] x, input logic [31:0] y,
                                             input logic [2:0] rm);
      logic   s;
      int     ex, ey, e;
      longint mx, my, num, q, rem, sig;
      bit     g, st, inc, xz, xi, xn, yz, yi, yn;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      xz = (ex == 0);
      xi = (ex == 255) && (x[22:0] == 23'h0);
      xn = (ex == 255) && (x[22:0] != 23'h0);
      yz = (ey == 0);
      yi = (ey == 255) && (y[22:0] == 23'h0);
      yn = (ey == 255) && (y[22:0] != 23'h0);
      if (xn || yn || (xz && yz) || (xi && yi)) return {3'b000, 32'h7fc00000};
      if (xi) return {3'b000, s, 8'hff, 23'h0};
      if (yz) return {3'b001, s, 8'hff, 23'h0};
      if (xz || yi) return {3'b000, s, 31'h0};
      mx  = longint'({1'b1, x[22:0]});
      my  = longint'({1'b1, y[22:0]});
      num = mx * 64'sd33554432;
      q   = num / my;
      rem = num % my;
      if (q >= 64'sd33554432) begin
         sig = q / 4;
         g   = ((q / 2) % 2) != 0;
         st  = ((q % 2) != 0) || (rem != 0);
         e   = ex - ey + 127;
      end else begin
         sig = q / 2;
         g   = (q % 2) != 0;
         st  = (rem != 0);
         e   = ex - ey + 126;
      end
      case (rm)
         3'd1:    inc = 1'b0;
         3'd2:    inc = s && (g || st);
         3'd3:    inc = !s && (g || st);
         3'd4:    inc = g;
         default: inc = g && (st || ((sig % 2) != 0));
      endcase
      sig = sig + longint'(inc);
      if (sig == 64'sd16777216) begin
         sig = 64'sd8388608;
         e   = e + 1;
      end
      if (e >= 255) return {3'b100, s, 8'hff, 23'h0};
      if (e <= 0)   return {3'b010, s, 31'h0};
      return {3'b000, s, 8'(e), 23'(sig)};
   endfunction

   // Every cycle a result is presented it must match the oldest outstanding model entry.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) chk("unexpected_result", {5'd0, 3'b000, fp_Z}, 40'd0);
         else                   chk("model", {5'd0, ovrf, udrf, dz, fp_Z}, {5'd0, exp_q[0]});
      end
   end

   // Retire the model entry on the result handshake.
   always @(posedge clk) begin
      if (!rst && out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
   end

   // One operation: wait for in_ready, accept, measure latency, check literal and model.
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                        input logic [34:0] lit, input bit use_lit, input int exp_lat,
                        input string name);
      int lat;
      int wait_cnt;
      wait_cnt = 0;
      @(negedge clk);
      while (!in_ready && wait_cnt < 100) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (!in_ready) begin
         chk({name, "_in_ready_timeout"}, 40'(in_ready), 40'd1);
         return;
      end
      fp_X     = x;
      fp_Y     = y;
      r_mode   = rm;
      in_valid = 1'b1;
      exp_q.push_back(model_div(x, y, rm));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, "_latency"}, 40'(lat), 40'(exp_lat));
      if (use_lit) begin
         chk({name, "_result"}, {5'd0, ovrf, udrf, dz, fp_Z}, {5'd0, lit});
         chk({name, "_model_pin"}, {5'd0, model_div(x, y, rm)}, {5'd0, lit});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      logic [31:0] rx, ry;
      bit          stayed_idle;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      fp_X      = '0;
      fp_Y      = '0;
      r_mode    = '0;
      #12;
      chk("reset_state", {in_ready, out_valid, ovrf, udrf, dz, 3'b000, fp_Z},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0});
      @(negedge clk);
      rst = 1'b0;

      // Basic divide and latency
      do_op(32'h40c00000, 32'h40000000, 3'd0, {3'b000, 32'h40400000}, 1, 28, "t1_1p5");

      // Rounding modes on 1/3, 2/3 and negative operands
      do_op(32'h3f800000, 32'h40400000, 3'd0, {3'b000, 32'h3eaaaaab}, 1, 28, "t2_rne");
      do_op(32'h3f800000, 32'h40400000, 3'd1, {3'b000, 32'h3eaaaaaa}, 1, 28, "t2_rtz");
      do_op(32'h3f800000, 32'h40400000, 3'd3, {3'b000, 32'h3eaaaaab}, 1, 28, "t2_rup");
      do_op(32'hbf800000, 32'h40400000, 3'd2, {3'b000, 32'hbeaaaaab}, 1, 28, "t2_rdn_neg");
      do_op(32'h3f800000, 32'h40400000, 3'd2, {3'b000, 32'h3eaaaaaa}, 1, 28, "t2_rdn_pos");
      do_op(32'hbf800000, 32'h40400000, 3'd3, {3'b000, 32'hbeaaaaaa}, 1, 28, "t2_rup_neg");
      do_op(32'h40000000, 32'h40400000, 3'd4, {3'b000, 32'h3f2aaaab}, 1, 28, "t2_rmm");
      do_op(32'h3f800000, 32'h40400000, 3'd7, {3'b000, 32'h3eaaaaab}, 1, 28, "t2_reserved");

      // Specials take the short path
      do_op(32'h3f800000, 32'h00000000, 3'd0, {3'b001, 32'h7f800000}, 1, 2, "t3_dz");
      do_op(32'h00000000, 32'h80000000, 3'd0, {3'b000, 32'h7fc00000}, 1, 2, "t3_zero_zero");
      do_op(32'h7f800000, 32'hff800000, 3'd0, {3'b000, 32'h7fc00000}, 1, 2, "t3_inf_inf");
      do_op(32'h7fc00001, 32'h3f800000, 3'd0, {3'b000, 32'h7fc00000}, 1, 2, "t3_nan");
      do_op(32'hff800000, 32'h3f800000, 3'd0, {3'b000, 32'hff800000}, 1, 2, "t3_inf_x");
      do_op(32'h3f800000, 32'hff800000, 3'd0, {3'b000, 32'h80000000}, 1, 2, "t3_inf_y");
      do_op(32'h00400000, 32'h3f800000, 3'd0, {3'b000, 32'h00000000}, 1, 2, "t3_subnormal");

      // Exponent range limits, then flags clear on the next accept
      do_op(32'h7f000000, 32'h3e800000, 3'd0, {3'b100, 32'h7f800000}, 1, 28, "t4_ovrf");
      do_op(32'h00800000, 32'h40000000, 3'd0, {3'b010, 32'h00000000}, 1, 28, "t4_udrf");
      do_op(32'h80800000, 32'h40000000, 3'd0, {3'b010, 32'h80000000}, 1, 28, "t4_udrf_neg");
      do_op(32'h3f800000, 32'h3f800000, 3'd0, {3'b000, 32'h3f800000}, 1, 28, "t4_flags_clear");

      // Extra normal operands checked against the model only
      for (int i = 0; i < 8; i++) begin
         rx = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
         ry = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
         do_op(rx, ry, 3'($urandom_range(0, 4)), 35'd0, 0, 28, "sweep");
      end

      // Back-pressure: result held, no new accept while waiting
      out_ready = 1'b0;
      do_op(32'h40c00000, 32'h40000000, 3'd0, {3'b000, 32'h40400000}, 1, 28, "t5_hold");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         fp_X     = 32'h3f800000;
         fp_Y     = 32'h40400000;
         @(posedge clk);
         #1;
         chk("t5_held", {in_ready, out_valid, 6'd0, fp_Z}, {1'b0, 1'b1, 6'd0, 32'h40400000});
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_handoff", {38'd0, in_ready, out_valid}, {38'd0, 1'b1, 1'b0});
      stayed_idle = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (out_valid || !in_ready) stayed_idle = 1'b0;
      end
      chk("t5_no_accept", 40'(stayed_idle), 40'd1);

      // Reset in the middle of the iteration aborts the operation
      @(negedge clk);
      fp_X     = 32'h3f800000;
      fp_Y     = 32'h40400000;
      r_mode   = 3'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("t6_in_reset", {38'd0, in_ready, out_valid}, {38'd0, 1'b1, 1'b0});
      rst = 1'b0;
      stayed_idle = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid || !in_ready) stayed_idle = 1'b0;
      end
      chk("t6_no_result", 40'(stayed_idle), 40'd1);
      do_op(32'h40c00000, 32'h40000000, 3'd0, {3'b000, 32'h40400000}, 1, 28, "t6_after");

      repeat (3) @(posedge clk);
      chk("queue_drained", 40'(exp_q.size()), 40'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
